// File: rtl/port_uart_tx.sv
// FIFO-buffered UART transmitter fed by a processor port write strobe (8N1 frames).
// Define PORT_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
//
// state  | meaning
// IDLE   | line high, not busy; pops the head byte as soon as the FIFO is non-empty
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | 8 data bits LSB first, CLKS_PER_BIT cycles each
// PARITY | even parity of the data byte (parity build only)
// STOP   | stop bit (high); pops straight into START when more bytes are queued
`timescale 1ns/1ps
module port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WrStrobe,
    input  logic [31:0] WrData,
    input  logic        ClearOvf,
    output logic        TxSerial,
    output logic        Busy,
    output logic        Full,
    output logic        Empty,
    output logic        Overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PORT_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            tx_q, tx_n, busy_q, ovf_q;
    logic            push, drop, pop, tick;
`ifdef PORT_UART_TX_PARITY_EN
    logic            parity_q;
`endif

    // Only the low byte of the port word goes on the line.
    logic unused_wr_hi;
    assign unused_wr_hi = ^WrData[31:8];

    assign push     = WrStrobe && !Full;
    assign drop     = WrStrobe && Full;
    assign tick     = (timer == T_LAST);
    assign Full     = (count == CNT_FULL);
    assign Empty    = (count == '0);
    assign TxSerial = tx_q;
    assign Busy     = busy_q;
    assign Overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= WrData[7:0];
    end

    // A write against a full FIFO is dropped even if a pop frees a slot that same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)          ovf_q <= 1'b1;
            else if (ClearOvf) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        tx_n    = 1'b1;
        case (state)
            IDLE: begin
                if (!Empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (tick) state_n = DATA;
            end
            DATA: begin
                tx_n = shreg[0];
                if (tick && bit_idx == 3'd7) begin
`ifdef PORT_UART_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef PORT_UART_TX_PARITY_EN
            PARITY: begin
                tx_n = parity_q;
                if (tick) state_n = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (!Empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line and Busy are registered so the serial output is glitch-free and both move together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef PORT_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            tx_q   <= tx_n;
            busy_q <= (state != IDLE);
            if (state == IDLE || tick) timer <= '0;
            else                       timer <= timer + 1'b1;
            if (pop) begin
                shreg   <= mem[rd_ptr];
                bit_idx <= '0;
`ifdef PORT_UART_TX_PARITY_EN
                parity_q <= ^mem[rd_ptr];
`endif
            end else if (state == DATA && tick) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end
endmodule

// File: doc/port_uart_tx.md
PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, byte entries buffered; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 WrStrobe  input  1  one-cycle write request from processor port logic.
REQ-006 WrData  input  32  processor PortOut word; only bits [7:0] are transmitted.
REQ-007 TxSerial  output  1  UART line; idle high.
REQ-008 Busy  output  1  high while a frame is being shifted out.
REQ-009 Full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-010 Empty  output  1  FIFO holds zero bytes.
REQ-011 Overflow  output  1  sticky; set when a write is dropped.
REQ-012 ClearOvf  input  1  synchronous clear of Overflow.

Function
REQ-013 Write accepted on a WrStrobe cycle when Full is low: WrData[7:0] stored at write pointer, pointer increments modulo FIFO_DEPTH.
REQ-014 WrStrobe while Full is low but a pop occurs the same cycle: write still accepted; occupancy unchanged.
REQ-015 WrStrobe while Full is high: byte dropped, FIFO unchanged, Overflow set next edge, even if a pop happens that cycle.
REQ-016 ClearOvf and a dropped write in the same cycle: Overflow ends set (set wins).
REQ-017 Occupancy counter width log2(FIFO_DEPTH)+1; Full = count==FIFO_DEPTH, Empty = count==0, both registered-consistent with the counter.
REQ-018 State machine states: IDLE, START, DATA, STOP (plus PARITY when enabled, REQ-030).
REQ-019 IDLE: TxSerial=1, Busy=0; if Empty low, pop head byte into shift register and go to START next edge (pop counts as FIFO read that cycle).
REQ-020 START: TxSerial=0 for CLKS_PER_BIT cycles, then DATA.
REQ-021 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; bit index 0..7, after bit 7 go to STOP.
REQ-022 STOP: TxSerial=1 for CLKS_PER_BIT cycles; then pop next byte directly into START if Empty low, else IDLE (no idle gap between back-to-back frames).
REQ-023 Busy high in every state except IDLE.
REQ-024 Latency: byte written into empty FIFO while IDLE -> TxSerial falls 2 clk edges after the write edge.
REQ-025 Bit timer counts 0..CLKS_PER_BIT-1 and wraps; frame length exactly 10*CLKS_PER_BIT cycles (11* with parity).
REQ-026 FIFO write and read pointers wrap from FIFO_DEPTH-1 to 0 with no data loss.

Reset
REQ-027 reset low asynchronously forces: state IDLE, TxSerial=1, Busy=0, Empty=1, Full=0, Overflow=0, pointers, counter, timers zero.
REQ-028 reset asserted mid-frame aborts frame immediately and discards all buffered bytes; line returns high without glitch to 0.
REQ-029 After reset deasserts, first accepted write starts a frame per REQ-024.

Configuration
REQ-030 Macro PORT_UART_TX_PARITY_EN defined: PARITY state inserted between DATA and STOP, transmitting even parity of the 8 data bits for CLKS_PER_BIT cycles; undefined: no PARITY state, DATA goes directly to STOP, 10-bit frame.

Verification
REQ-031 CLKS_PER_BIT=4, write 0x00000055 while idle -> TxSerial: 0,1,0,1,0,1,0,1,0,1 each 4 cycles, Busy high 40 cycles, then Empty=1, Busy=0.
REQ-032 FIFO_DEPTH=4, five strobes of 0x11..0x15 on consecutive cycles while IDLE -> first pops immediately, all five accepted and sent back-to-back, no gap, Overflow=0.
REQ-033 Six writes with frame in progress and FIFO full after fourth queued -> fifth/sixth dropped, Overflow=1 sticky, ClearOvf pulse -> Overflow=0.
REQ-034 reset low at bit 3 of frame 0xA5 with 2 bytes queued -> TxSerial=1, Empty=1, Busy=0 same cycle; no further frames after release.
REQ-035 With PORT_UART_TX_PARITY_EN, write 0x07 -> parity bit 1, frame 11*CLKS_PER_BIT cycles; write 0x03 -> parity bit 0.
REQ-036 Write while Full coincident with STOP-end pop -> byte dropped, Overflow=1, occupancy drops by one.
